fetch_decode_stage: RTL

FETCH_DECODE_STAGE -- requirements
Module: fetch_decode_stage

---
 rtl/mips_pkg.sv | 25 ++
 rtl/instr_field_decode.sv | 26 ++
 rtl/fetch_decode_stage.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the fetch/decode slice.
//   - opcode constants of the zero-extending immediate instructions
//   - fetch FSM state enumeration
//   - bubble encoding loaded into IF/ID on flush
//   - helper that classifies an opcode as zero- or sign-extending
package mips_pkg;

    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI = 6'h0E;
    localparam logic [5:0] OP_LUI  = 6'h0F;

    localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } fd_state_t;

    function automatic logic is_zero_ext(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI) || (op == OP_LUI);
    endfunction

endpackage

// File: rtl/instr_field_decode.sv
// instr_field_decode: purely combinational field split of the IF/ID word.
// Ports:
//   i_valid   - IF/ID holds a real instruction
//   i_instr   - IF/ID instruction word
//   o_rs/o_rt/o_rd - register fields [25:21], [20:16], [15:11]
//   o_imm16   - immediate field [15:0]
//   o_ext_op  - 0 zero-extend (andi/ori/xori/lui), 1 sign-extend; 0 for a bubble
module instr_field_decode (
    input  logic        i_valid,
    input  logic [31:0] i_instr,
    output logic [4:0]  o_rs,
    output logic [4:0]  o_rt,
    output logic [4:0]  o_rd,
    output logic [15:0] o_imm16,
    output logic        o_ext_op
);
    import mips_pkg::*;

    assign o_rs     = i_instr[25:21];
    assign o_rt     = i_instr[20:16];
    assign o_rd     = i_instr[15:11];
    assign o_imm16  = i_instr[15:0];
    // A bubble (opcode 0) would otherwise decode as sign-extend.
    assign o_ext_op = i_valid & ~is_zero_ext(i_instr[31:26]);

endmodule

// File: rtl/fetch_decode_stage.sv
// fetch_decode_stage: PC, fetch FSM (IDLE/FETCH/HOLD), one-entry skid buffer
// and IF/ID pipeline register, with combinational field decode of IF/ID.
// Optional feature macro: DELAY_SLOT_EN -- a word acked together with pc_ld
// is kept (delay slot) instead of being squashed.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   stall, flush      - hazard controls for IF/ID
//   pc_ld, pc_target  - PC redirect
//   imem_req/addr     - fetch request, address = current PC
//   imem_ack/rdata    - fetch response
//   id_valid/instr/pc4 - IF/ID contents
//   id_rs/rt/rd/imm16/ext_op - decoded fields of id_instr
module fetch_decode_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        pc_ld,
    input  logic [31:0] pc_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc4,
    output logic [4:0]  id_rs,
    output logic [4:0]  id_rt,
    output logic [4:0]  id_rd,
    output logic [15:0] id_imm16,
    output logic        id_ext_op
);
    import mips_pkg::*;

`ifdef DELAY_SLOT_EN
    localparam logic DS = 1'b1;
`else
    localparam logic DS = 1'b0;
`endif

    fd_state_t   r_state;
    logic        r_req;
    logic [31:0] r_pc;
    logic        r_id_valid;
    logic [31:0] r_id_instr;
    logic [31:0] r_id_pc4;
    logic [31:0] r_skid_instr;
    logic [31:0] r_skid_pc4;

    logic [31:0] w_pc4;
    logic        w_fetch_ack;
    logic        w_bubble;
    logic        w_skid_load;

    assign w_pc4       = r_pc + 32'd4;
    assign w_fetch_ack = (r_state == S_FETCH) & imem_ack;
    // Without delay slots a redirect squashes whatever IF/ID would receive.
    assign w_bubble    = flush | (pc_ld & ~DS);
    assign w_skid_load = w_fetch_ack & stall & ~flush & (~pc_ld | DS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_req        <= 1'b0;
            r_pc         <= RESET_PC;
            r_id_valid   <= 1'b0;
            r_id_instr   <= BUBBLE_INSTR;
            r_id_pc4     <= '0;
            r_skid_instr <= '0;
            r_skid_pc4   <= '0;
        end else begin
            // PC: redirect wins; otherwise advance only on a kept fetch.
            if (pc_ld)
                r_pc <= pc_target;
            else if (w_fetch_ack && !flush)
                r_pc <= w_pc4;

            // IF/ID register
            if (w_bubble) begin
                r_id_valid <= 1'b0;
                r_id_instr <= BUBBLE_INSTR;
                r_id_pc4   <= '0;
            end else if (w_fetch_ack && !stall) begin
                r_id_valid <= 1'b1;
                r_id_instr <= imem_rdata;
                r_id_pc4   <= w_pc4;
            end else if ((r_state == S_HOLD) && !stall && !pc_ld) begin
                r_id_valid <= 1'b1;
                r_id_instr <= r_skid_instr;
                r_id_pc4   <= r_skid_pc4;
            end

            // Skid buffer occupancy is implied by S_HOLD.
            if (w_skid_load) begin
                r_skid_instr <= imem_rdata;
                r_skid_pc4   <= w_pc4;
            end

            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                    r_req   <= 1'b1;
                end
                S_FETCH: begin
                    if (w_skid_load) begin
                        r_state <= S_HOLD;
                        r_req   <= 1'b0;
                    end else begin
                        r_state <= S_FETCH;
                        r_req   <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (flush || pc_ld || !stall) begin
                        r_state <= S_FETCH;
                        r_req   <= 1'b1;
                    end else begin
                        r_state <= S_HOLD;
                        r_req   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req  = r_req;
    assign imem_addr = r_pc;
    assign id_valid  = r_id_valid;
    assign id_instr  = r_id_instr;
    assign id_pc4    = r_id_pc4;

    instr_field_decode u_decode (
        .i_valid  (r_id_valid),
        .i_instr  (r_id_instr),
        .o_rs     (id_rs),
        .o_rt     (id_rt),
        .o_rd     (id_rd),
        .o_imm16  (id_imm16),
        .o_ext_op (id_ext_op)
    );

endmodule
